// File: rtl/tristate_bus_ctrl_pkg.sv
// Shared definitions for the tristate pad bus sequencer:
// state encodings, counter width and parameter range helper.
package tristate_bus_ctrl_pkg;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WR_DRIVE = 2'd1;
    localparam logic [1:0] S_WR_TURN  = 2'd2;
    localparam logic [1:0] S_RD_WAIT  = 2'd3;

    function automatic bit cycles_ok(input int n);
        return (n >= 1) && (n <= CNT_MAX);
    endfunction

endpackage

// File: rtl/tristate_bus_ctrl.sv
// Core-side sequencer for an IOBUF pad bus: turns single-beat
// read/write commands into drive, release and sample phases.
module tristate_bus_ctrl
    import tristate_bus_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int WR_CYCLES   = 2,
    parameter int RD_CYCLES   = 3,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [WIDTH-1:0] cmd_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             busy,
    output logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_t,
    input  logic [WIDTH-1:0] pad_o
);

    if (!cycles_ok(WR_CYCLES) || !cycles_ok(RD_CYCLES) ||
        !cycles_ok(TURN_CYCLES)) begin : g_bad_param
        $error("tristate_bus_ctrl: cycle parameters must be 1..15");
    end

    localparam logic [CNT_W-1:0] WR_LOAD   = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LOAD   = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pad_t_q, pad_t_d;
    logic [WIDTH-1:0] pad_i_q, pad_i_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pad_t_d     = pad_t_q;
        pad_i_d     = pad_i_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_write) begin
                        state_d = S_WR_DRIVE;
                        cnt_d   = WR_LOAD;
                        pad_t_d = 1'b0;
                        pad_i_d = cmd_wdata;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = RD_LOAD;
                    end
                end
            end
            S_WR_DRIVE: begin
                if (cnt_zero) begin
                    state_d = S_WR_TURN;
                    cnt_d   = TURN_LOAD;
                    pad_t_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WR_TURN: begin
                if (cnt_zero) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RD_WAIT: begin
                if (cnt_zero) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pad_o;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pad_t_d = 1'b1;
            end
        endcase
    end

    // Reset releases the bus without waiting for a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pad_t_q     <= 1'b1;
            pad_i_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pad_t_q     <= pad_t_d;
            pad_i_q     <= pad_i_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // One flop fans out to every T pin so all bits switch together
    assign pad_t     = {WIDTH{pad_t_q}};
    assign pad_i     = pad_i_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule
